// File: rtl/uc_seq.sv
// uc_seq: sequencing control unit for the single-cycle 8-bit microcontroller.
// Decodes Opcode and the registered zero flag into datapath controls, adds a
// one-cycle BOOT state, a sticky HALT state and a debug single-step mode, and
// counts retired instructions.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   Opcode[5:0]  instruction bits [15:10]
//   zero         registered zero flag
//   dbg, step    single-step mode select, step request (level)
//   s_inc        1 = PC+1, 0 = jump target
//   s_inm        immediate operand select
//   we, wez      register-file / zero-flag write enables
//   ALUOp[2:0]   ALU operation select
//   pc_en        PC register load enable
//   halted       core stopped
//   instret      retired-instruction count (wraps)
//   illegal      sticky illegal-opcode flag (UC_ILLEGAL_TRAP_EN builds only)
//
// Build option: define UC_ILLEGAL_TRAP_EN to turn opcodes 0001xx..0011xx into
// HALT plus the sticky illegal flag; otherwise they are NOPs.
module uc_seq #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [2:0]  ALUOP_LI = 3'b000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             zero,
  input  logic             dbg,
  input  logic             step,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we,
  output logic             wez,
  output logic [2:0]       ALUOp,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] instret
`ifdef UC_ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;
  logic   step_d;
  logic   exec;
  logic   stop_op;
  logic   illegal_op;
  logic   retire;

  // In single-step mode only the rising edge of step executes, so holding
  // step high or dropping dbg while step is high cannot execute twice.
  assign exec   = (state == RUN) && (!dbg || (step && !step_d));
  assign halted = (state == HALT);

  always_comb begin
    s_inc      = 1'b1;
    s_inm      = 1'b0;
    we         = 1'b0;
    wez        = 1'b0;
    ALUOp      = '0;
    pc_en      = 1'b0;
    stop_op    = 1'b0;
    illegal_op = 1'b0;
    if (exec) begin
      casez (Opcode)
        6'b1?????: begin
          ALUOp = Opcode[4:2];
          we    = 1'b1;
          wez   = 1'b1;
          pc_en = 1'b1;
        end
        6'b01????: begin
          ALUOp = ALUOP_LI;
          s_inm = 1'b1;
          we    = 1'b1;
          pc_en = 1'b1;
        end
        6'b000000: begin
          s_inc = 1'b0;
          pc_en = 1'b1;
        end
        6'b000001: begin
          s_inc = ~zero;
          pc_en = 1'b1;
        end
        6'b000010: begin
          s_inc = zero;
          pc_en = 1'b1;
        end
        6'b000011: stop_op = 1'b1;
        default: begin
`ifdef UC_ILLEGAL_TRAP_EN
          stop_op    = 1'b1;
          illegal_op = 1'b1;
`else
          pc_en      = 1'b1;
`endif
        end
      endcase
    end
  end

  // HALT (and a trapped illegal opcode) retires even though the PC holds.
  assign retire = exec && (pc_en || stop_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= BOOT;
      step_d  <= 1'b0;
      instret <= '0;
    end else begin
      step_d <= step;
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (stop_op) state <= HALT;
        HALT:    state <= HALT;
        default: state <= BOOT;
      endcase
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

`ifdef UC_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)           illegal <= 1'b0;
    else if (illegal_op) illegal <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_uc_seq.sv
// Self-checking bench for uc_seq: directed steps followed by random stimulus,
// all checked against a behavioural model of the sequencing rules.
module tb_uc_seq;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    Opcode = '0;
  logic          zero = 1'b0;
  logic          dbg = 1'b0;
  logic          step = 1'b0;
  logic          s_inc, s_inm, we, wez, pc_en, halted;
  logic [2:0]    ALUOp;
  logic [CW-1:0] instret;
`ifdef UC_ILLEGAL_TRAP_EN
  logic          illegal;
`endif

  uc_seq #(.CNT_W(CW), .ALUOP_LI(3'b000)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero), .dbg(dbg),
    .step(step), .s_inc(s_inc), .s_inm(s_inm), .we(we), .wez(wez),
    .ALUOp(ALUOp), .pc_en(pc_en), .halted(halted), .instret(instret)
`ifdef UC_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  bit m_known = 0, m_boot = 0, m_halted = 0, m_step_d = 0, m_ill = 0;
  int unsigned m_cnt = 0;

  // Last sampled outputs
  logic s_pc, s_w, s_wz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_stop_op(input int op);
`ifdef UC_ILLEGAL_TRAP_EN
    return (op >= 3 && op <= 15);
`else
    return (op == 3);
`endif
  endfunction

  // One clock: check outputs mid-cycle against the model, then advance the
  // model over the rising edge.
  task automatic tick();
    int op;
    bit ex;
    logic e_inc, e_inm, e_we, e_wez, e_pc;
    logic [2:0] e_alu;
    @(negedge clk);
    op = int'(Opcode);
    ex = m_known && !m_boot && !m_halted && (!dbg || (step && !m_step_d));
    e_inc = 1; e_inm = 0; e_we = 0; e_wez = 0; e_pc = 0; e_alu = 0;
    if (ex) begin
      if (op >= 32) begin
        e_alu = 3'((op / 4) % 8); e_we = 1; e_wez = 1; e_pc = 1;
      end else if (op >= 16) begin
        e_inm = 1; e_we = 1; e_pc = 1;
      end else if (op == 0) begin
        e_inc = 0; e_pc = 1;
      end else if (op == 1) begin
        e_inc = !zero; e_pc = 1;
      end else if (op == 2) begin
        e_inc = zero; e_pc = 1;
      end else if (!is_stop_op(op)) begin
        e_pc = 1;
      end
    end
    s_pc = pc_en; s_w = we; s_wz = wez;
    if (m_known) begin
      chk("pc_en", pc_en, e_pc);
      chk("we", we, e_we);
      chk("wez", wez, e_wez);
      chk("s_inc", s_inc, e_inc);
      chk("s_inm", s_inm, e_inm);
      chk("ALUOp", ALUOp, e_alu);
      chk("halted", halted, m_halted);
      chk("instret", instret, m_cnt);
`ifdef UC_ILLEGAL_TRAP_EN
      chk("illegal", illegal, m_ill);
`endif
    end
    @(posedge clk);
    if (reset) begin
      m_known = 1; m_boot = 1; m_halted = 0; m_cnt = 0; m_step_d = 0; m_ill = 0;
    end else begin
      m_step_d = step;
      if (m_boot) m_boot = 0;
      else if (ex) begin
        m_cnt = (m_cnt + 1) % (1 << CW);
        if (is_stop_op(op)) begin
          m_halted = 1;
          if (op != 3) m_ill = 1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
    tick(); // BOOT
  endtask

  initial begin
    int unsigned base;
    int pulses;

    // Reset and first instruction
    Opcode = 6'b100100; dbg = 0; step = 0; zero = 0;
    reset = 1; tick(); tick(); reset = 0;
    chk("reset_instret", instret, 0);
    chk("reset_halted", halted, 0);
    tick();
    chk("boot_we", s_w, 0);
    chk("boot_pc_en", s_pc, 0);
    tick();
    chk("alu_pc_en", s_pc, 1);
    chk("alu_instret", instret, 1);

    // Load immediate, then jumps with both zero values
    Opcode = 6'b010000; tick();
    for (int z = 0; z < 2; z++) begin
      zero = z[0];
      Opcode = 6'b000000; tick();
      Opcode = 6'b000001; tick();
      Opcode = 6'b000010; tick();
    end

    // HALT is sticky and freezes everything until reset
    Opcode = 6'b000011; tick();
    chk("halt_halted", halted, 1);
    base = 32'(instret);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      Opcode = 6'($urandom); zero = 1'($urandom);
      tick();
      pulses += int'(s_pc) + int'(s_w) + int'(s_wz);
    end
    chk("halt_no_activity", pulses, 0);
    chk("halt_instret_frozen", instret, base);
    reset = 1; tick(); reset = 0;
    chk("halt_reset_halted", halted, 0);
    chk("halt_reset_instret", instret, 0);
    tick();

    // Single-step: 5 high, 3 low, 1 high -> two executes
    dbg = 1; Opcode = 6'b100000;
    base = 32'(instret);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      step = (i < 5 || i == 8);
      tick();
      pulses += int'(s_pc);
    end
    step = 0; tick();
    chk("step_pulses", pulses, 2);
    chk("step_instret", instret, (base + 2) % (1 << CW));

    // Dropping dbg while step is high executes once per cycle, no extra
    dbg = 1; step = 1; tick();
    dbg = 0; tick();

    // Opcode 000101: NOP or illegal trap depending on build
    dbg = 0; step = 0; Opcode = 6'b000101;
    base = 32'(instret);
    tick();
`ifdef UC_ILLEGAL_TRAP_EN
    chk("trap_halted", halted, 1);
    chk("trap_illegal", illegal, 1);
    chk("trap_pc_en", s_pc, 0);
`else
    chk("nop_pc_en", s_pc, 1);
    chk("nop_we", s_w, 0);
    chk("nop_instret", instret, (base + 1) % (1 << CW));
`endif
    do_reset();

    // Random phase, covering counter wrap and mode changes
    for (int i = 0; i < 400; i++) begin
      Opcode = 6'($urandom);
      if (Opcode[5:4] == 2'b00 && $urandom_range(3) != 0) Opcode[5] = 1'b1;
      zero = 1'($urandom);
      dbg  = ($urandom_range(3) == 0);
      step = 1'($urandom);
      reset = ($urandom_range(60) == 0) || (m_halted && $urandom_range(5) == 0);
      tick();
    end
    reset = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
